// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants for the MEM-stage load/store controller.
//   - funct3 encodings for load/store size and sign
//   - MEM-stage FSM state encoding (2 bits)
//   - default access timeout in REQ-state cycles
// -----------------------------------------------------------------------------
package mem_pkg;

    // Load/store funct3 encodings (RV32I)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // MEM-stage FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Maximum number of REQ cycles before an access is aborted
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for one load/store access.
// Ports:
//   is_load    in   1   access is a load (stores otherwise)
//   funct3     in   3   size/sign field
//   addr_lo    in   2   low address bits (byte offset in the word)
//   wdata      in  32   store data from the pipeline
//   rdata      in  32   read word from the bus
//   be         out  4   byte enables for the bus
//   wdata_lane out 32   store data replicated across the lanes
//   load_ext   out 32   selected and sign/zero-extended load data
//   legal      out  1   funct3 is valid for this access direction
//   aligned    out  1   address is naturally aligned for this size
// -----------------------------------------------------------------------------
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_ext,
    output logic        legal,
    output logic        aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // Loads always fetch the full word; the lane is picked from rdata.
        be         = 4'b1111;
        wdata_lane = wdata;
        load_ext   = rdata;
        legal      = 1'b0;
        aligned    = 1'b0;
        case (funct3)
            F3_B: begin
                legal    = 1'b1;
                aligned  = 1'b1;
                load_ext = {{24{byte_sel[7]}}, byte_sel};
                if (!is_load) begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
            end
            F3_H: begin
                legal    = 1'b1;
                aligned  = ~addr_lo[0];
                load_ext = {{16{half_sel[15]}}, half_sel};
                if (!is_load) begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
            end
            F3_W: begin
                legal   = 1'b1;
                aligned = (addr_lo == 2'b00);
            end
            F3_BU: begin
                // Unsigned forms only exist for loads
                legal    = is_load;
                aligned  = 1'b1;
                load_ext = {24'h0, byte_sel};
            end
            F3_HU: begin
                legal    = is_load;
                aligned  = ~addr_lo[0];
                load_ext = {16'h0, half_sel};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Sequences the MEM stage of the RV32I pipeline against a req/ready data bus.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   mem_read_m            load in MEM stage
//   mem_write_m           store in MEM stage (ignored if mem_read_m is set)
//   funct3_m, addr_m      access size/sign and effective address
//   wdata_m               store data
//   bus_req/we/addr/wdata/be  bus request side
//   bus_ready, bus_rdata  bus completion and read data
//   load_data_m           extended load result, valid in DONE
//   stall_m               freeze upstream pipeline registers
//   misalign_err          one-cycle pulse in DONE: misaligned or illegal funct3
//   timeout_err           one-cycle pulse in DONE: access aborted
//
// Bus handshake: bus_req rises on entry to REQ and stays high, with we/addr/
// be/wdata held constant, until the first cycle in which bus_ready is high
// at the clock edge; that edge completes the transfer (and samples bus_rdata
// for reads). bus_ready outside REQ carries no meaning and is ignored.
// -----------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int AW      = 32
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read_m,
    input  logic          mem_write_m,
    input  logic [2:0]    funct3_m,
    input  logic [31:0]   addr_m,
    input  logic [31:0]   wdata_m,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    output logic [3:0]    bus_be,
    input  logic          bus_ready,
    input  logic [31:0]   bus_rdata,
    output logic [31:0]   load_data_m,
    output logic          stall_m,
    output logic          misalign_err,
    output logic          timeout_err
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          access;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_load;
    logic          lane_legal;
    logic          lane_aligned;

    assign access = mem_read_m | mem_write_m;

    // Driven straight from state so an async reset drops the request at once.
    assign bus_req = (state == ST_REQ);

    // Released in DONE so the pipeline advances exactly once per access.
    assign stall_m = ((state == ST_IDLE) && access) || (state == ST_REQ);

    // A read wins when both controls are set, so mem_read_m alone is the
    // direction.
    lsu_lane_align u_lane (
        .is_load    (mem_read_m),
        .funct3     (funct3_m),
        .addr_lo    (addr_m[1:0]),
        .wdata      (wdata_m),
        .rdata      (bus_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .load_ext   (lane_load),
        .legal      (lane_legal),
        .aligned    (lane_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= 4'b0000;
            load_data_m  <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (lane_legal && lane_aligned) begin
                            // Bus fields are captured once so they stay
                            // stable for the whole REQ phase.
                            state     <= ST_REQ;
                            cnt       <= '0;
                            bus_we    <= ~mem_read_m;
                            bus_addr  <= {addr_m[AW-1:2], 2'b00};
                            bus_be    <= lane_be;
                            bus_wdata <= mem_read_m ? 32'h0 : lane_wdata;
                        end else begin
                            state        <= ST_DONE;
                            misalign_err <= 1'b1;
                            load_data_m  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ready) begin
                        state       <= ST_DONE;
                        cnt         <= '0;
                        load_data_m <= bus_we ? 32'h0 : lane_load;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ST_DONE;
                        cnt         <= '0;
                        timeout_err <= 1'b1;
                        load_data_m <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Inputs still hold the same instruction here; return to
                    // IDLE without looking at them.
                    state        <= ST_IDLE;
                    cnt          <= '0;
                    misalign_err <= 1'b0;
                    timeout_err  <= 1'b0;
                    bus_we       <= 1'b0;
                    bus_be       <= 4'b0000;
                    bus_wdata    <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
